// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: holds the PC, drives the instruction memory
// address, and captures each 32-bit fetched word into a registered instruction.
// The decoder receives that instruction through a valid/ready handshake.
//
// Latency: mem_ar is the PC register itself. The word is captured on the edge
// that samples mem_data. After reset release, the first instruction is valid
// two edges later: one IDLE settle edge, then the capture edge.
// Backpressure: while ir_valid is high and ir_ready is low, ir, ir_pc and pc
// all hold. A new word is captured only when the IR slot is empty or is being
// consumed in the same cycle.
//
// Ports:
//   Clk, Reset          rising-edge clock; synchronous active-high reset
//   mem_ar  [15:0]      halfword address to instruction memory (== pc)
//   mem_data[31:0]      {H[ar+1], H[ar]} returned combinationally
//   ir, ir_pc, ir_valid instruction word, its address, and its valid flag
//   ir_ready            the decoder takes ir this cycle
//   redirect_en/_pc     load a new PC (bit 0 is forced to zero); top priority
//   halted              high while stopped on HALT_WORD
//   fetch_count         completed handshakes, only when FETCH_PERF_EN is defined
//   stall_count         backpressured cycles, only when FETCH_PERF_EN is defined
//
// Optional build macro: FETCH_PERF_EN. When it is undefined, the two counter
// ports remain and are tied to zero.

module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [31:0] HALT_WORD = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [15:0] mem_ar,
  input  logic [31:0] mem_data,
  output logic [31:0] ir,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic        halted,
  output logic [15:0] fetch_count,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  // The instruction word and the address it came from always move together.
  typedef struct packed {
    logic [31:0] word;
    logic [15:0] pc;
  } fetch_rec_t;

  state_t     state, state_nxt;
  logic [15:0] pc, pc_nxt;
  fetch_rec_t ir_q, ir_nxt;
  logic       ir_valid_q, ir_valid_nxt;
  logic       halted_q, halted_nxt;

  logic       handshake;
  logic       capture;
  logic       is_halt_word;

  // A transfer completes whenever valid meets ready, even in a redirect cycle.
  assign handshake    = ir_valid_q && ir_ready;
  assign capture      = (state == FETCH) && !redirect_en && (!ir_valid_q || ir_ready);
  assign is_halt_word = (mem_data == HALT_WORD);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      ir_q       <= ir_nxt;
      ir_valid_q <= ir_valid_nxt;
      halted_q   <= halted_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    ir_nxt       = ir_q;
    ir_valid_nxt = ir_valid_q;
    halted_nxt   = halted_q;

    if (redirect_en) begin
      // Masking with 16'hFFFE keeps the halfword address even. A pending
      // instruction is dropped; if it was handed over this cycle, the handshake
      // already consumed it.
      pc_nxt       = redirect_pc & 16'hFFFE;
      ir_valid_nxt = 1'b0;
      halted_nxt   = 1'b0;
      state_nxt    = FETCH;
    end else begin
      // Retiring the current instruction. A capture below overrides this.
      if (handshake) begin
        ir_valid_nxt = 1'b0;
      end

      unique case (state)
        IDLE: begin
          // One settle cycle after the reset load of the PC; nothing is sampled.
          state_nxt = FETCH;
        end

        FETCH: begin
          if (capture) begin
            if (is_halt_word) begin
              // The halt word is never presented. ir and ir_pc keep the last
              // real instruction.
              ir_valid_nxt = 1'b0;
              halted_nxt   = 1'b1;
              state_nxt    = HALT;
            end else begin
              ir_nxt.word  = mem_data;
              ir_nxt.pc    = pc;
              ir_valid_nxt = 1'b1;
              pc_nxt       = pc + 16'd2;  // wraps modulo 2^16
            end
          end
        end

        HALT: begin
          // Sticky: only a redirect (above) or Reset leaves this state.
          state_nxt = HALT;
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign mem_ar   = pc;
  assign ir       = ir_q.word;
  assign ir_pc    = ir_q.pc;
  assign ir_valid = ir_valid_q;
  assign halted   = halted_q;

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef FETCH_PERF_EN
  logic        stall;
  logic [15:0] fetch_cnt_q;
  logic [15:0] stall_cnt_q;

  assign stall = ir_valid_q && !ir_ready;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (handshake) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (stall)     stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  assign fetch_count = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit, driven against a behavioural halfword memory.
// Expected values are hand-computed from the memory image loaded below.
module tb_instr_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] mem_ar;
  logic [31:0] mem_data;
  logic [31:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic        halted;
  logic [15:0] fetch_count;
  logic [15:0] stall_count;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  instr_fetch_unit #(.RESET_PC(16'h0000), .HALT_WORD(32'h0000_0000)) dut (
    .Clk(Clk), .Reset(Reset), .mem_ar(mem_ar), .mem_data(mem_data),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .halted(halted),
    .fetch_count(fetch_count), .stall_count(stall_count)
  );

  always #5 Clk = ~Clk;

  // Halfword memory with 16-bit address wrap for the upper half of the word.
  logic [15:0] mem [0:65535];
  logic [15:0] ar_hi;
  assign ar_hi    = mem_ar + 16'd1;
  assign mem_data = {mem[ar_hi], mem[mem_ar]};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [31:0] eir,
                         input logic [15:0] epc, input logic [15:0] ear, input logic eh);
    chk({tag, ".ir_valid"}, {31'd0, ir_valid}, {31'd0, ev});
    chk({tag, ".ir"},       ir, eir);
    chk({tag, ".ir_pc"},    {16'd0, ir_pc}, {16'd0, epc});
    chk({tag, ".mem_ar"},   {16'd0, mem_ar}, {16'd0, ear});
    chk({tag, ".halted"},   {31'd0, halted}, {31'd0, eh});
  endtask

  task automatic chk_cnt(input string tag, input int ef, input int es);
    chk({tag, ".fetch_count"}, {16'd0, fetch_count}, PERF ? ef : 0);
    chk({tag, ".stall_count"}, {16'd0, stall_count}, PERF ? es : 0);
  endtask

  // Drive inputs one time unit after an edge, then sample one unit after the next edge.
  task automatic step(input logic rst, input logic rdy, input logic rd, input logic [15:0] rpc);
    Reset       = rst;
    ir_ready    = rdy;
    redirect_en = rd;
    redirect_pc = rpc;
    @(posedge Clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        ev;
    logic [31:0] eir;
    logic [15:0] epc;
    logic [15:0] ear;
    logic        eh;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int last_pc;
    int viol;
    bit got_halt;

    // Every row is: inputs for the coming edge, then the outputs expected after it.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0,          16'h0, 16'h0, 1'b0}; // reset
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0,          16'h0, 16'h0, 1'b0}; // reset
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0,          16'h0, 16'h0, 1'b0}; // E0 idle
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0001_04E8,  16'h0, 16'h2, 1'b0}; // E1
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0002_0320,  16'h2, 16'h4, 1'b0}; // E2
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0002_0320,  16'h2, 16'h4, 1'b0}; // stall
    vecs[6] = '{1'b0, 1'b0, 1'b1, 32'h0002_0320,  16'h2, 16'h4, 1'b0}; // stall
    vecs[7] = '{1'b0, 1'b0, 1'b1, 32'h0002_0320,  16'h2, 16'h4, 1'b0}; // stall
    vecs[8] = '{1'b0, 1'b1, 1'b1, 32'hA005_A004,  16'h4, 16'h6, 1'b0}; // resume

    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    mem[0] = 16'h04E8; mem[1] = 16'h0001; mem[2] = 16'h0320; mem[3] = 16'h0002;
    for (int i = 4; i < 20; i++) mem[i] = 16'hA000 + 16'(i);
    mem[20] = 16'h0000; mem[21] = 16'h0000;
    mem[16'hFFFE] = 16'h1111; mem[16'hFFFF] = 16'h2222;

    Reset = 1'b1; ir_ready = 1'b1; redirect_en = 1'b0; redirect_pc = 16'h0;

    // Reset, first captures, backpressure, and resume.
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].rst, vecs[i].rdy, 1'b0, 16'h0);
      chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eir, vecs[i].epc, vecs[i].ear, vecs[i].eh);
    end
    chk_cnt("vec_cnt", 2, 3);

    // Sequential run into the halt word at H[20..21].
    last_pc = -1;
    got_halt = 1'b0;
    for (int i = 0; i < 20 && !got_halt; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0);
      if (halted) got_halt = 1'b1;
      else if (ir_valid) last_pc = ir_pc;
    end
    chk("halt.reached", {31'd0, got_halt}, 32'd1);
    chk("halt.last_pc", last_pc, 18);
    chk_all("halt", 1'b0, 32'hA013_A012, 16'd18, 16'd20, 1'b1);
    viol = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0);
      if (ir_valid || !halted || mem_ar != 16'd20) viol++;
    end
    chk("halt.sticky_violations", viol, 0);

    // Redirect out of HALT, with the odd target forced even.
    step(1'b0, 1'b1, 1'b1, 16'h0005);
    chk_all("redir5", 1'b0, 32'hA013_A012, 16'd18, 16'd4, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    chk_all("redir5.cap", 1'b1, 32'hA005_A004, 16'd4, 16'd6, 1'b0);

    // Redirect to the top of memory, then the PC wraps through zero.
    step(1'b0, 1'b1, 1'b1, 16'hFFFE);
    chk_all("redirFFFE", 1'b0, 32'hA005_A004, 16'd4, 16'hFFFE, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    chk_all("wrap.cap0", 1'b1, 32'h2222_1111, 16'hFFFE, 16'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    chk_all("wrap.cap1", 1'b1, 32'h0001_04E8, 16'h0, 16'h2, 1'b0);

    // Backpressure on the first instruction after a fresh reset.
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk_all("bp.rst", 1'b0, 32'h0, 16'h0, 16'h0, 1'b0);
    chk_cnt("bp.rst", 0, 0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk_all("bp.E1", 1'b1, 32'h0001_04E8, 16'h0, 16'h2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0);
      chk_all($sformatf("bp.hold%0d", i), 1'b1, 32'h0001_04E8, 16'h0, 16'h2, 1'b0);
    end
    chk_cnt("bp.stalled", 0, 3);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    chk_all("bp.resume", 1'b1, 32'h0002_0320, 16'h2, 16'h4, 1'b0);
    chk_cnt("bp.resume", 1, 3);

    // Reset mid-stream while an instruction is pending.
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk_all("mid.rst", 1'b0, 32'h0, 16'h0, 16'h0, 1'b0);
    chk_cnt("mid.rst", 0, 0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    chk_all("mid.E0", 1'b0, 32'h0, 16'h0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    chk_all("mid.E1", 1'b1, 32'h0001_04E8, 16'h0, 16'h2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch sequencer that drives the instruction memory address and consumes its 32-bit read word. It holds the program counter, fetches one two-halfword instruction per accepted transfer, and presents it to the decoder through a valid/ready handshake. It supports branch redirect and stops in a sticky halt state when it fetches the halt word.

## Interface
- RESET_PC, 16'h0000: PC value loaded on reset; must be even.
- HALT_WORD, 32'h0000_0000: fetched word that stops fetching.

- Clk  input  1  rising-edge clock.
- Reset  input  1  reset, synchronous, active-high.
- mem_ar  output  16  instruction memory halfword address; equals PC.
- mem_data  input  32  memory read word {H[ar+1], H[ar]}, combinational from mem_ar.
- ir  output  32  registered instruction.
- ir_pc  output  16  address the current ir was fetched from.
- ir_valid  output  1  ir holds an unconsumed instruction.
- ir_ready  input  1  decoder accepts ir this cycle.
- redirect_en  input  1  load a new PC (branch/jump taken).
- redirect_pc  input  16  redirect target; bit 0 is ignored (forced 0).
- halted  output  1  high while in HALT.

## Operation
- States: IDLE, FETCH, HALT.
- Reset high at a clock edge: state=IDLE, pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, halted=0. mem_ar=pc at all times, so mem_ar=RESET_PC.
- IDLE: lets the memory settle after its reset load. Captures nothing. Goes to FETCH on the next edge.
- Capture condition: state==FETCH && !redirect_en && (!ir_valid || ir_ready).
- On capture with mem_data != HALT_WORD: ir<=mem_data, ir_pc<=pc, ir_valid<=1, pc<=pc+2.
- On capture with mem_data == HALT_WORD: ir_valid<=0, pc unchanged, state<=HALT, halted<=1. ir and ir_pc keep their old values.
- No capture, with ir_valid && ir_ready: ir_valid<=0.
- ir_valid && !ir_ready: ir, ir_pc and pc all hold (backpressure).
- redirect_en has top priority in any state, including IDLE and HALT:
  - pc<={redirect_pc[15:1],1'b0}, ir_valid<=0, halted<=0, state<=FETCH.
  - Nothing is captured that cycle.
  - If ir_valid && ir_ready in the same cycle, the transfer counts as completed.
- HALT: sticky. Leaves only on Reset or redirect_en. ir_ready can still drain a pending ir.
- PC arithmetic: 16-bit modulo. pc=16'hFFFE advances to 16'h0000.

## Timing
- mem_ar is a direct copy of the pc register (no combinational logic). mem_data is sampled in the same cycle.
- Let E0 be the first edge with Reset low. E0: IDLE->FETCH. E1: first capture, so ir_valid is high after E1.
- Throughput: one instruction per cycle while ir_ready stays high.
- Redirect penalty: ir_valid is low for the cycle after the redirect edge. The target instruction is captured on the next edge.
- Halt: halted rises on the edge that samples HALT_WORD. ir_valid never presents the halt word.
- Reset mid-operation: applies on that edge regardless of state. Any pending ir is discarded.

## Configuration
- FETCH_PERF_EN defined: adds output fetch_count[15:0] and output stall_count[15:0].
  - fetch_count increments on every completed handshake (ir_valid && ir_ready).
  - stall_count increments on every cycle with ir_valid && !ir_ready.
  - Both clear on Reset and wrap at 16'hFFFF->0.
- FETCH_PERF_EN undefined: both ports still exist and are tied to 0. No counter logic is built.

## Test plan
- Memory preloaded H[0]=16'h04E8, H[1]=16'h0001, H[2]=16'h0320, H[3]=16'h0002; ir_ready=1; release reset -> after E1: ir=32'h0001_04E8, ir_pc=0. After E2: ir=32'h0002_0320, ir_pc=2, mem_ar=4.
- Same load, ir_ready=0 for 3 cycles after the first capture -> ir=32'h0001_04E8 and mem_ar=2 hold. With FETCH_PERF_EN, stall_count=3. Raise ir_ready -> next ir=32'h0002_0320.
- H[20]=H[21]=0, sequential program from 0, ir_ready=1 -> last valid ir_pc=18. halted=1 with mem_ar=20. ir_valid stays 0 for 10+ cycles.
- While halted, redirect_en=1, redirect_pc=16'h0005 -> next cycle halted=0, mem_ar=4, ir_valid=0. The following edge gives ir=32'h{H[5],H[4]}, ir_pc=4.
- Redirect with redirect_pc=16'hFFFE, H[FFFE]=16'h1111, H[FFFF]=16'h2222, H[0]=16'h04E8, H[1]=16'h0001 -> ir=32'h2222_1111, then pc wraps and ir=32'h0001_04E8 with ir_pc=0.
- Assert Reset for one edge while ir_valid=1 mid-stream -> ir_valid=0, ir=0, mem_ar=RESET_PC, halted=0. With FETCH_PERF_EN, counters=0. The first capture occurs two edges after release.
